// File: rtl/water_supply_arbiter.sv
// -----------------------------------------------------------------------------
// water_supply_arbiter
//   Shares one water-inlet valve among N_REQ washer controllers. One owner at a
//   time, chosen round-robin, with a settle gap of GAP idle cycles after every
//   release or revoke. A global pause closes the valve and freezes the owner's
//   hold time without giving up the grant.
//
//   Optional feature macro: WSA_TIMEOUT_EN
//     defined   : an owner is revoked after MAX_HOLD unpaused grant cycles and
//                 timeout_o pulses for one cycle.
//     undefined : no hold limit; the grant is kept until the owner drops its
//                 request; timeout_o is tied low.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high
//   req_i        in   [N_REQ]  level request per washer; dropping it releases
//   pause_i      in   global pause (door open / supply fault)
//   grant_o      out  [N_REQ]  one-hot owner, registered; zero when no owner
//   grant_id_o   out  [$clog2(N_REQ)] binary owner index, valid while busy_o
//   busy_o       out  high while in the GRANT state
//   valve_on_o   out  busy_o & ~pause_i
//   timeout_o    out  registered one-cycle pulse on a forced revoke
//   state_o      out  [2] current FSM state (0 IDLE, 1 GRANT, 2 SETTLE)
//
// Handshake: req_i is a level request; the grant appears the cycle after the
// request is seen in IDLE and stays until the request drops (or is revoked).
// Requests are only sampled in IDLE.
// -----------------------------------------------------------------------------
module water_supply_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 15,
  parameter int GAP      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_i,
  input  logic                     pause_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     busy_o,
  output logic                     valve_on_o,
  output logic                     timeout_o,
  output logic [1:0]               state_o
);

  localparam int IDW   = $clog2(N_REQ);
  localparam int GAP_W = $clog2(GAP + 1);

  if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 1 || GAP < 1) begin : g_bad_param
    $error("water_supply_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
`ifdef WSA_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               timeout_q, timeout_d;
`endif

  // Round-robin pick: scan downward so the lowest offset from rr_ptr_q wins.
  logic               pick_found;
  logic [IDW-1:0]     pick_idx;
  logic [IDW-1:0]     cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr_q) + k) % N_REQ);
      if (req_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      gap_cnt_q  <= '0;
`ifdef WSA_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      gap_cnt_q  <= gap_cnt_d;
`ifdef WSA_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    gap_cnt_d  = gap_cnt_q;
`ifdef WSA_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!pause_i && pick_found) begin
          state_d    = ST_GRANT;
          grant_d    = N_REQ'(1) << pick_idx;
          grant_id_d = pick_idx;
          // Move the pointer past the new owner so it has lowest priority next.
          rr_ptr_d   = IDW'((int'(pick_idx) + 1) % N_REQ);
`ifdef WSA_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      ST_GRANT: begin
        // Release wins over pause: a washer may always give the valve back.
        if (!req_i[grant_id_q]) begin
          state_d   = ST_SETTLE;
          grant_d   = '0;
          gap_cnt_d = '0;
        end
`ifdef WSA_TIMEOUT_EN
        else if (pause_i) begin
          hold_cnt_d = hold_cnt_q;
        end else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
          state_d   = ST_SETTLE;
          grant_d   = '0;
          gap_cnt_d = '0;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
`endif
      end
      ST_SETTLE: begin
        if (gap_cnt_q == GAP_W'(GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    grant_o    = grant_q;
    grant_id_o = grant_id_q;
    busy_o     = (state_q == ST_GRANT);
    valve_on_o = (state_q == ST_GRANT) && !pause_i;
    state_o    = state_q;
`ifdef WSA_TIMEOUT_EN
    timeout_o  = timeout_q;
`else
    timeout_o  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_water_supply_arbiter.sv
// -----------------------------------------------------------------------------
// tb_water_supply_arbiter
//   Directed scenarios followed by a randomized run, all checked every cycle
//   against a behavioural model of the arbiter (owner / cycles used / settle
//   cycles left / next priority index). Follows WSA_TIMEOUT_EN like the DUT.
// -----------------------------------------------------------------------------
module tb_water_supply_arbiter;

  localparam int N_REQ    = 4;
  localparam int MAX_HOLD = 15;
  localparam int GAP      = 2;
`ifdef WSA_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]         req = '0;
  logic                     pause = 1'b0;
  logic [N_REQ-1:0]         grant;
  logic [$clog2(N_REQ)-1:0] grant_id;
  logic                     busy;
  logic                     valve_on;
  logic                     timeout;
  logic [1:0]               state;

  water_supply_arbiter #(
    .N_REQ(N_REQ), .MAX_HOLD(MAX_HOLD), .GAP(GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req),
    .pause_i    (pause),
    .grant_o    (grant),
    .grant_id_o (grant_id),
    .busy_o     (busy),
    .valve_on_o (valve_on),
    .timeout_o  (timeout),
    .state_o    (state)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model
  int m_owner = -1;   // -1 when nobody owns the valve
  int m_used  = 0;    // unpaused grant cycles already consumed by owner
  int m_cool  = 0;    // settle cycles still to wait before arbitrating
  int m_next  = 0;    // index that gets first look at the next arbitration
  bit m_to    = 1'b0; // timeout pulse expected this cycle

  task automatic model_reset();
    m_owner = -1; m_used = 0; m_cool = 0; m_next = 0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [N_REQ-1:0] r, input logic p);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1; m_cool = GAP;
      end else if (p) begin
        m_used = m_used;
      end else if (TEN && (m_used + 1 == MAX_HOLD)) begin
        m_owner = -1; m_cool = GAP; m_to = 1'b1;
      end else begin
        m_used++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (!p && (r != '0)) begin
      for (int k = 0; k < N_REQ; k++) begin
        int c;
        c = (m_next + k) % N_REQ;
        if (r[c] && m_owner < 0) m_owner = c;
      end
      m_used = 0;
      m_next = (m_owner + 1) % N_REQ;
    end
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [N_REQ-1:0] e_grant;
    e_grant = '0;
    if (m_owner >= 0) e_grant[m_owner] = 1'b1;
    chk("grant",    32'(grant),    32'(e_grant));
    chk("busy",     32'(busy),     32'(m_owner >= 0));
    chk("timeout",  32'(timeout),  32'(m_to));
    chk("valve_on", 32'(valve_on), 32'((m_owner >= 0) && !pause));
    if (m_owner >= 0) chk("grant_id", 32'(grant_id), 32'(m_owner));
  endtask

  // Driver: one clock, inputs held stable across the edge, check 1 ns later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step(req, pause);
      #1;
      check_outputs();
    end
  endtask

  initial begin
    // Reset state
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_grant",    32'(grant),    32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_timeout",  32'(timeout),  32'd0);
    chk("rst_valve",    32'(valve_on), 32'd0);
    reset = 1'b0;
    tick(2);

    // T1 single requester, grant after one cycle, release and settle
    req = 4'b0001;
    tick(1);
    chk("t1_grant_latency", 32'(grant), 32'h1);
    tick(4);
    req = 4'b0000;
    tick(1);
    chk("t1_release", 32'(grant), 32'h0);
    tick(GAP + 2);

    // T2 all requesting: round-robin rotation with revokes (if enabled)
    req = 4'b1111;
    tick(5 * (MAX_HOLD + GAP + 1) + 4);
    req = 4'b0000;
    tick(GAP + 3);

    // T3 pause in the middle of an ownership
    req = 4'b0010;
    tick(6);
    pause = 1'b1;
    tick(10);
    pause = 1'b0;
    tick(MAX_HOLD + 4);
    req = 4'b0000;
    tick(GAP + 3);

    // T4 release while paused
    req = 4'b0100;
    tick(3);
    pause = 1'b1;
    tick(2);
    req = 4'b0000;
    tick(1);
    chk("t4_release_paused", 32'(grant), 32'h0);
    tick(3);
    pause = 1'b0;
    tick(GAP + 2);

    // T5 asynchronous reset during a grant
    req = 4'b1111;
    tick(4);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_busy",  32'(busy),  32'd0);
    req = 4'b0110;
    reset = 1'b0;
    tick(1);
    chk("t5_after_rst", 32'(grant), 32'h2);
    tick(4);
    req = 4'b0000;
    tick(GAP + 3);

    // T6 long single ownership
    req = 4'b0001;
    tick(40);
    req = 4'b0000;
    tick(GAP + 3);

    // Randomized traffic with sticky requests and occasional pause
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
      pause = ($urandom_range(0, 7) == 0);
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
